gf_mix_column_unit: RTL and testbench

Parametrised, handshaked MixColumns/InverseMixColumns engine for the AES datapath. It accepts a block of NUM_COLS 32-bit columns and a mode bit. One column is mixed per clock through a shared GF(2^8) column mixer. The result is held in an output buffer until the consumer takes it. It replaces the per-constant combinational multipliers with one sequential unit that serves both the encrypt and decrypt round paths.

---
 rtl/gf_pkg.sv | 48 ++++
 rtl/gf_mix_column_unit_if.sv | 41 ++++
 rtl/gf_column_mixer.sv | 20 ++
 rtl/gf_mix_column_unit.sv | 125 ++++++++++++
 tb/tb_gf_mix_column_unit.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf_pkg.sv
// Shared types, GF(2^8) arithmetic and MixColumns coefficient sets for the
// column-mix unit. The optional pass-through path is enabled by GF_MIXCOL_BYPASS_EN.
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mixcol_state_t;

  // AES reduction polynomial x^8 + x^4 + x^3 + x + 1 with the x^8 term dropped
  localparam logic [7:0] GF_POLY = 8'h1B;

  // Circulant coefficient rows, coefficient 0 in the MSB byte
  localparam logic [31:0] FWD_COEF = 32'h02030101;
  localparam logic [31:0] INV_COEF = 32'h0E0B0D09;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant coefficient this folds down to
  // the few xtime/XOR terms that coefficient actually needs.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = b;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Row r = XOR over k of coef[(k - r) mod 4] * s_k, row 0 in the MSB byte
  function automatic logic [31:0] mix_column(input logic [31:0] col, input logic [31:0] coef);
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        res[31-8*r -: 8] ^= gf_mul(col[31-8*k -: 8], coef[31-8*((k-r+4)%4) -: 8]);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gf_mix_column_unit_if.sv
// Block-transfer handshake between a producer/consumer and gf_mix_column_unit.
// The bypass signal exists only when GF_MIXCOL_BYPASS_EN is defined.
interface gf_mix_column_unit_if #(
  parameter int NUM_COLS = 4
);

  logic                    in_valid;
  logic                    in_ready;
  logic                    inverse;
  logic [32*NUM_COLS-1:0]  data_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [32*NUM_COLS-1:0]  data_out;
  logic                    busy;
`ifdef GF_MIXCOL_BYPASS_EN
  logic                    bypass;
`endif

`ifdef GF_MIXCOL_BYPASS_EN
  modport master (
    output in_valid, inverse, data_in, out_ready, bypass,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, inverse, data_in, out_ready, bypass,
    output in_ready, out_valid, data_out, busy
  );
`else
  modport master (
    output in_valid, inverse, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, inverse, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );
`endif

endinterface

// File: rtl/gf_column_mixer.sv
// Combinational MixColumns / InverseMixColumns on a single 32-bit column.
// Row 0 byte sits at the MSBs of col_in and col_out.
module gf_column_mixer
  import gf_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inverse,
  output logic [31:0] col_out
);

  logic [31:0] fwd_col;
  logic [31:0] inv_col;

  // Both constant-coefficient networks are built and selected afterwards, so
  // neither needs a general variable-coefficient multiplier.
  assign fwd_col = mix_column(col_in, FWD_COEF);
  assign inv_col = mix_column(col_in, INV_COEF);
  assign col_out = inverse ? inv_col : fwd_col;

endmodule

// File: rtl/gf_mix_column_unit.sv
// Sequential MixColumns engine: one column per clock through a shared mixer,
// result held until taken. GF_MIXCOL_BYPASS_EN adds a pass-through block mode.
module gf_mix_column_unit
  import gf_pkg::*;
#(
  parameter int NUM_COLS = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  gf_mix_column_unit_if.slave   bus
);

  localparam int DW    = 32 * NUM_COLS;
  localparam int CNT_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  mixcol_state_t     state_q, state_d;
  logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
  logic [DW-1:0]     blk_q, blk_d;
  logic              inv_q, inv_d;
  logic [DW-1:0]     dout_q, dout_d;

  logic              accept;
  logic              last_col;
  logic              take_bypass;
  logic [31:0]       mix_in;
  logic [31:0]       mix_out;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign last_col = (col_cnt_q == CNT_W'(NUM_COLS - 1));

`ifdef GF_MIXCOL_BYPASS_EN
  assign take_bypass = bus.bypass;
`else
  assign take_bypass = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      col_cnt_q <= '0;
      // NOTE: the latched block and output buffer are plain registers, not a
      // RAM, so clearing them on reset is cheap and makes an aborted block
      // leave nothing visible on data_out.
      blk_q     <= '0;
      inv_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      blk_q     <= blk_d;
      inv_q     <= inv_d;
      dout_q    <= dout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred when a branch leaves the state unchanged.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = take_bypass ? DONE : BUSY;
      BUSY:    if (last_col)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Column select into the shared mixer
  // ---------------------------------------------------------------------------
  always_comb begin
    mix_in = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (col_cnt_q == CNT_W'(i)) mix_in = blk_q[DW-32*(i+1) +: 32];
    end
  end

  gf_column_mixer u_mixer (
    .col_in  (mix_in),
    .inverse (inv_q),
    .col_out (mix_out)
  );

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    col_cnt_d = col_cnt_q;
    blk_d     = blk_q;
    inv_d     = inv_q;
    dout_d    = dout_q;

    if (accept) begin
      // Later changes on data_in/inverse cannot reach the result after this
      blk_d     = bus.data_in;
      inv_d     = bus.inverse;
      col_cnt_d = '0;
      if (take_bypass) dout_d = bus.data_in;
    end else if (state_q == BUSY) begin
      col_cnt_d = last_col ? '0 : col_cnt_q + CNT_W'(1);
      for (int i = 0; i < NUM_COLS; i++) begin
        if (col_cnt_q == CNT_W'(i)) dout_d[DW-32*(i+1) +: 32] = mix_out;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from state only
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q == BUSY);
    bus.out_valid = (state_q == DONE);
    bus.data_out  = dout_q;
  end

endmodule

// File: tb/tb_gf_mix_column_unit.sv
// Self-checking bench for gf_mix_column_unit: one 4-column and one 1-column
// instance, table vectors, scoreboarded random round trips and corner cases.
module tb_gf_mix_column_unit;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  gf_mix_column_unit_if #(.NUM_COLS(4)) bus4 ();
  gf_mix_column_unit_if #(.NUM_COLS(1)) bus1 ();

  gf_mix_column_unit #(.NUM_COLS(4)) u_dut4 (.clk(clk), .n_rst(n_rst), .bus(bus4));
  gf_mix_column_unit #(.NUM_COLS(1)) u_dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] tb_xt(input logic [7:0] b);
    return (b << 1) ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = tb_xt(b);
    x4 = tb_xt(x2);
    x8 = tb_xt(x4);
    case (c)
      4'h1:    return b;
      4'h2:    return x2;
      4'h3:    return x2 ^ b;
      4'h9:    return x8 ^ b;
      4'hB:    return x8 ^ x2 ^ b;
      4'hD:    return x8 ^ x4 ^ b;
      4'hE:    return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] tb_mix(input logic [31:0] col, input logic inv);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = col;
    if (!inv)
      return {tb_mul(s0,2) ^ tb_mul(s1,3) ^ s2 ^ s3,
              s0 ^ tb_mul(s1,2) ^ tb_mul(s2,3) ^ s3,
              s0 ^ s1 ^ tb_mul(s2,2) ^ tb_mul(s3,3),
              tb_mul(s0,3) ^ s1 ^ s2 ^ tb_mul(s3,2)};
    return {tb_mul(s0,4'hE) ^ tb_mul(s1,4'hB) ^ tb_mul(s2,4'hD) ^ tb_mul(s3,4'h9),
            tb_mul(s0,4'h9) ^ tb_mul(s1,4'hE) ^ tb_mul(s2,4'hB) ^ tb_mul(s3,4'hD),
            tb_mul(s0,4'hD) ^ tb_mul(s1,4'h9) ^ tb_mul(s2,4'hE) ^ tb_mul(s3,4'hB),
            tb_mul(s0,4'hB) ^ tb_mul(s1,4'hD) ^ tb_mul(s2,4'h9) ^ tb_mul(s3,4'hE)};
  endfunction

  function automatic logic [127:0] tb_mix_blk(input logic [127:0] blk, input logic inv);
    logic [127:0] res;
    for (int c = 0; c < 4; c++) res[127-32*c -: 32] = tb_mix(blk[127-32*c -: 32], inv);
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- consumer side of the 4-column unit ----------------
  logic [127:0] sb[$];
  int           rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus4.out_ready = 1'b0;
      1:       bus4.out_ready = 1'b1;
      default: bus4.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (n_rst) begin
      if (bus4.busy || bus4.out_valid) check("in_ready_low", 128'(bus4.in_ready), 128'd0);
      if (bus4.out_valid && bus4.out_ready) begin
        if (sb.size() == 0) check("unexpected_out", 128'd1, 128'd0);
        else                check("blk_data", bus4.data_out, sb.pop_front());
      end
    end
  end

  // ---------------- producer tasks ----------------
  task automatic send4(input logic [127:0] d, input logic inv, input logic [127:0] exp_v);
    bit ok;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b1;
    bus4.data_in  = d;
    bus4.inverse  = inv;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus4.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 128'd0, 128'd1);
      bus4.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    check("one_in_flight", 128'(sb.size()), 128'd0);
    sb.push_back(exp_v);
    #1;
    bus4.in_valid = 1'b0;
    bus4.data_in  = rnd128();
    bus4.inverse  = ~inv;
  endtask

  task automatic drain4();
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && bus4.in_ready) return;
    end
    check("drain_timeout", 128'(sb.size()), 128'd0);
    sb.delete();
  endtask

  task automatic run1(input logic [31:0] d, input logic inv, input logic [31:0] exp_v,
                      input logic hold_rdy);
    @(posedge clk);
    #1;
    bus1.out_ready = hold_rdy;
    bus1.in_valid  = 1'b1;
    bus1.data_in   = d;
    bus1.inverse   = inv;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    bus1.data_in  = ~d;
    bus1.inverse  = ~inv;
    check("c1_busy", 128'(bus1.busy), 128'd1);
    check("c1_early_valid", 128'(bus1.out_valid), 128'd0);
    @(posedge clk);
    #1;
    check("c1_out_valid", 128'(bus1.out_valid), 128'd1);
    check("c1_data", 128'(bus1.data_out), 128'(exp_v));
    check("c1_in_ready_low", 128'(bus1.in_ready), 128'd0);
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("c1_released", 128'(bus1.out_valid), 128'd0);
    check("c1_idle", 128'(bus1.in_ready), 128'd1);
    bus1.out_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [127:0] din;
    logic         inv;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] d, f;
    int           cnt;

    vecs[0] = '{din: 128'hDB135345_F20A225C_D4D4D4D5_2D26314C, inv: 1'b0,
                dout: 128'h8E4DA1BC_9FDC589D_D5D5D7D6_4D7EBDF8};
    vecs[1] = '{din: 128'h8E4DA1BC_9FDC589D_D5D5D7D6_4D7EBDF8, inv: 1'b1,
                dout: 128'hDB135345_F20A225C_D4D4D4D5_2D26314C};
    vecs[2] = '{din: 128'hD4BF5D30_E0B452AE_B84111F1_1E2798E5, inv: 1'b0,
                dout: 128'h046681E5_E0CB199A_48F8D37A_2806264C};
    vecs[3] = '{din: 128'h046681E5_E0CB199A_48F8D37A_2806264C, inv: 1'b1,
                dout: 128'hD4BF5D30_E0B452AE_B84111F1_1E2798E5};
    vecs[4] = '{din: {4{32'hC6C6C6C6}}, inv: 1'b1, dout: {4{32'hC6C6C6C6}}};
    vecs[5] = '{din: 128'h0, inv: 1'b0, dout: 128'h0};

    bus4.in_valid = 1'b0;  bus4.inverse = 1'b0;  bus4.data_in = '0;
    bus1.in_valid = 1'b0;  bus1.inverse = 1'b0;  bus1.data_in = '0;
    bus1.out_ready = 1'b0;
`ifdef GF_MIXCOL_BYPASS_EN
    bus4.bypass = 1'b0;
    bus1.bypass = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    #1;
    check("rst_in_ready", 128'(bus4.in_ready), 128'd1);
    check("rst_out_valid", 128'(bus4.out_valid), 128'd0);
    check("rst_busy", 128'(bus4.busy), 128'd0);
    check("rst_data_out", bus4.data_out, 128'd0);
    check("rst1_data_out", 128'(bus1.data_out), 128'd0);

    // Single-column unit: forward, then inverse with out_ready held high
    run1(32'hDB135345, 1'b0, 32'h8E4DA1BC, 1'b0);
    run1(32'h8E4DA1BC, 1'b1, 32'hDB135345, 1'b1);

    // Table vectors on the 4-column unit, with accept-to-valid latency
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) begin
      send4(vecs[i].din, vecs[i].inv, vecs[i].dout);
      cnt = 1;
      while (!bus4.out_valid && cnt < 50) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      check($sformatf("latency_v%0d", i), 128'(cnt), 128'd5);
      drain4();
    end

    // Random forward/inverse round trips with throttled consumer
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      d = rnd128();
      f = tb_mix_blk(d, 1'b0);
      send4(d, 1'b0, f);
      send4(f, 1'b1, d);
    end
    drain4();

    // Output held stable while the consumer stalls
    rdy_mode = 0;
    d = rnd128();
    f = tb_mix_blk(d, 1'b0);
    send4(d, 1'b0, f);
    for (int n = 0; n < 20 && !bus4.out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      bus4.in_valid = 1'($urandom_range(0, 1));
      bus4.data_in  = rnd128();
      bus4.inverse  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("stall_valid", 128'(bus4.out_valid), 128'd1);
      check("stall_data", bus4.data_out, f);
    end
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    rdy_mode = 1;
    drain4();

    // Reset in the middle of BUSY with column counter at 2
    d = rnd128();
    send4(d, 1'b0, tb_mix_blk(d, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    check("abort_out_valid", 128'(bus4.out_valid), 128'd0);
    check("abort_data_out", bus4.data_out, 128'd0);
    check("abort_busy", 128'(bus4.busy), 128'd0);
    sb.delete();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    #1;
    check("abort_in_ready", 128'(bus4.in_ready), 128'd1);
    d = rnd128();
    send4(d, 1'b1, tb_mix_blk(d, 1'b1));
    drain4();

`ifdef GF_MIXCOL_BYPASS_EN
    // Bypassed block on the single-column unit: one edge, never busy
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b1;
    bus1.bypass   = 1'b1;
    bus1.inverse  = 1'b0;
    bus1.data_in  = 32'hC6C6C6C6;
    @(posedge clk);
    #1;
    check("byp_out_valid", 128'(bus1.out_valid), 128'd1);
    check("byp_data", 128'(bus1.data_out), 128'(32'hC6C6C6C6));
    check("byp_busy", 128'(bus1.busy), 128'd0);
    bus1.in_valid  = 1'b0;
    bus1.bypass    = 1'b0;
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.out_ready = 1'b0;
    run1(32'hC6C6C6C6, 1'b0, 32'hC6C6C6C6, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
